// File: rtl/alu_seq_ctrl.sv
// ALU issue/sequencing controller.
// Accepts one operation at a time from decode, holds its operands and control
// steady on the alu_* outputs, waits out the operation's execution latency,
// captures the combinational ALU result and presents it to writeback with a
// valid/ready handshake. A new op can be accepted on the same edge that the
// previous result is handed off.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no op in flight; ready to accept
//   EXEC  | op issued to ALU; cnt counts remaining execution cycles
//   DONE  | result captured; out_valid high until writeback takes it
module alu_seq_ctrl #(
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_Op_code,
    input  logic [5:0]  in_R_ins,
    input  logic [1:0]  in_WW,
    input  logic [63:0] in_rA,
    input  logic [63:0] in_rB,
    input  logic [4:0]  in_rD,

    output logic [63:0] alu_rA,
    output logic [63:0] alu_rB,
    output logic [5:0]  alu_Op_code,
    output logic [5:0]  alu_R_ins,
    output logic [1:0]  alu_WW,
    input  logic [63:0] alu_result,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rD,
    output logic        out_wen,

    output logic        busy
);

    localparam logic [5:0] R_ALU = 6'b101010;

    localparam logic [5:0] RI_VMULEU = 6'b001000;
    localparam logic [5:0] RI_VMULOU = 6'b001001;
    localparam logic [5:0] RI_VSQEU  = 6'b010000;
    localparam logic [5:0] RI_VSQOU  = 6'b010001;
    localparam logic [5:0] RI_VDIV   = 6'b001110;
    localparam logic [5:0] RI_VMOD   = 6'b001111;
    localparam logic [5:0] RI_VSQRT  = 6'b010010;

    // Lowest and highest R-type function codes that write a register.
    localparam logic [5:0] RI_WEN_LO = 6'b000001;
    localparam logic [5:0] RI_WEN_HI = 6'b010010;

    localparam int LAT_MAX = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
    localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(LAT_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lat_sel;
    logic [4:0]       rd_hold;
    logic             accept;
    logic             complete;
    logic             wen_sel;

    // Execution latency of the op currently offered on the issue port.
    always_comb begin
        lat_sel = CNT_ONE;
        if (in_Op_code == R_ALU) begin
            case (in_R_ins)
                RI_VMULEU, RI_VMULOU, RI_VSQEU, RI_VSQOU: lat_sel = CNT_MUL;
                RI_VDIV, RI_VMOD, RI_VSQRT:               lat_sel = CNT_DIV;
                default:                                  lat_sel = CNT_ONE;
            endcase
        end
    end

    // Register write enable for the op held on the alu_* outputs.
    always_comb begin
        wen_sel = (alu_Op_code == R_ALU) &&
                  (alu_R_ins >= RI_WEN_LO) && (alu_R_ins <= RI_WEN_HI);
    end

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        // A count of 0 in EXEC cannot occur; treating it as terminal keeps
        // the counter from ever wrapping.
        complete  = (state == EXEC) && (cnt <= CNT_ONE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // FSM next-state and latency counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                    cnt_next   = lat_sel;
                end
            end
            EXEC: begin
                if (cnt <= CNT_ONE) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt - CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_next = EXEC;
                        cnt_next   = lat_sel;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Issue registers (held until the next accept) and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_rA      <= '0;
            alu_rB      <= '0;
            alu_Op_code <= '0;
            alu_R_ins   <= '0;
            alu_WW      <= '0;
            rd_hold     <= '0;
            out_data    <= '0;
            out_rD      <= '0;
            out_wen     <= 1'b0;
        end else begin
            if (accept) begin
                alu_rA      <= in_rA;
                alu_rB      <= in_rB;
                alu_Op_code <= in_Op_code;
                alu_R_ins   <= in_R_ins;
                alu_WW      <= in_WW;
                rd_hold     <= in_rD;
            end
            if (complete) begin
                out_data <= alu_result;
                out_rD   <= rd_hold;
                out_wen  <= wen_sel;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model.
module tb_alu_seq_ctrl;

    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 8;

    localparam logic [5:0] R_ALU   = 6'b101010;
    localparam logic [5:0] OP_LOAD = 6'b100000;
    localparam logic [5:0] VADD    = 6'b000001;
    localparam logic [5:0] VAND    = 6'b000011;
    localparam logic [5:0] VOR     = 6'b000100;
    localparam logic [5:0] VMULEU  = 6'b001000;
    localparam logic [5:0] VDIV    = 6'b001110;
    localparam logic [5:0] VSQRT   = 6'b010010;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_Op_code;
    logic [5:0]  in_R_ins;
    logic [1:0]  in_WW;
    logic [63:0] in_rA;
    logic [63:0] in_rB;
    logic [4:0]  in_rD;
    logic [63:0] alu_rA;
    logic [63:0] alu_rB;
    logic [5:0]  alu_Op_code;
    logic [5:0]  alu_R_ins;
    logic [1:0]  alu_WW;
    logic [63:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rD;
    logic        out_wen;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_Op_code(in_Op_code), .in_R_ins(in_R_ins), .in_WW(in_WW),
        .in_rA(in_rA), .in_rB(in_rB), .in_rD(in_rD),
        .alu_rA(alu_rA), .alu_rB(alu_rB),
        .alu_Op_code(alu_Op_code), .alu_R_ins(alu_R_ins), .alu_WW(alu_WW),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rD(out_rD), .out_wen(out_wen),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] ww);
        int w;
        logic [63:0] m;
        logic [63:0] r;
        w = 8 << ww;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        r = '0;
        for (int i = 0; i < 64; i += w)
            r |= ((((a >> i) & m) + ((b >> i) & m)) & m) << i;
        return r;
    endfunction

    function automatic logic [63:0] alu_model(input logic [5:0] op, input logic [5:0] rins,
                                              input logic [1:0] ww, input logic [63:0] a,
                                              input logic [63:0] b);
        if (op == R_ALU && rins == VADD) return lane_add(a, b, ww);
        if (op == R_ALU && rins == VAND) return a & b;
        if (op == R_ALU && rins == VOR)  return a | b;
        return a ^ {b[62:0], b[63]} ^ {op, 52'd0, rins};
    endfunction

    function automatic int exp_lat(input logic [5:0] op, input logic [5:0] rins);
        if (op != R_ALU) return 1;
        if (rins == 6'd8 || rins == 6'd9 || rins == 6'd16 || rins == 6'd17) return LAT_MUL;
        if (rins == 6'd14 || rins == 6'd15 || rins == 6'd18) return LAT_DIV;
        return 1;
    endfunction

    function automatic logic exp_wen(input logic [5:0] op, input logic [5:0] rins);
        return (op == R_ALU) && (int'(rins) >= 1) && (int'(rins) <= 18);
    endfunction

    // Behavioural ALU sitting on the DUT's alu_* outputs.
    assign alu_result = alu_model(alu_Op_code, alu_R_ins, alu_WW, alu_rA, alu_rB);

    task automatic set_op(input logic [5:0] op, input logic [5:0] rins, input logic [1:0] ww,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_Op_code = op;
        in_R_ins   = rins;
        in_WW      = ww;
        in_rA      = a;
        in_rB      = b;
        in_rD      = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_op(6'd0, 6'd0, 2'd0, 64'd0, 64'd0, 5'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_wen !== 1'b0) begin n_fail++; $display("FAIL rst_out_wen: got %b expected 0", out_wen); end
        n_checks++; if (out_data !== 64'd0 || out_rD !== 5'd0) begin n_fail++; $display("FAIL rst_out_data: got %h/%h expected 0/0", out_data, out_rD); end
        n_checks++; if (alu_rA !== 64'd0 || alu_rB !== 64'd0) begin n_fail++; $display("FAIL rst_alu_ops: got %h/%h expected 0/0", alu_rA, alu_rB); end
        n_checks++; if ({alu_Op_code, alu_R_ins, alu_WW} !== 14'd0) begin n_fail++; $display("FAIL rst_alu_ctrl: got %h expected 0", {alu_Op_code, alu_R_ins, alu_WW}); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vadd;
        int n;
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(R_ALU, VADD, 2'b01, 64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001, 5'd5);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vadd_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL vadd_latency: got %0d expected 1", n); end
        n_checks++; if (out_data !== 64'h0002_0003_0004_0005) begin n_fail++; $display("FAIL vadd_data: got %h expected 0002000300040005", out_data); end
        n_checks++; if (out_wen !== 1'b1 || out_rD !== 5'd5) begin n_fail++; $display("FAIL vadd_wen_rd: got %b/%0d expected 1/5", out_wen, out_rD); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL vadd_drain: got valid %b busy %b expected 0 0", out_valid, busy); end
    endtask

    task automatic test_vdiv_hold;
        int n;
        int n_bad_ready;
        logic [63:0] a1, b1, a2, b2;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(R_ALU, VDIV, 2'b10, a1, b1, 5'd6);
        @(posedge clk); #1;
        set_op(R_ALU, VOR, 2'b00, a2, b2, 5'd7);
        @(negedge clk);
        n = 0; n_bad_ready = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (in_ready !== 1'b0) n_bad_ready++;
            @(posedge clk); n++; @(negedge clk);
        end
        n_checks++; if (n != LAT_DIV) begin n_fail++; $display("FAIL vdiv_latency: got %0d expected %0d", n, LAT_DIV); end
        n_checks++; if (n_bad_ready != 0) begin n_fail++; $display("FAIL vdiv_in_ready_low: got %0d high cycles expected 0", n_bad_ready); end
        n_checks++; if (out_data !== alu_model(R_ALU, VDIV, 2'b10, a1, b1) || out_rD !== 5'd6) begin n_fail++; $display("FAIL vdiv_data: got %h/%0d expected %h/6", out_data, out_rD, alu_model(R_ALU, VDIV, 2'b10, a1, b1)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vdiv_done_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || alu_R_ins !== VOR || alu_rA !== a2) begin n_fail++; $display("FAIL vdiv_second_accept: got valid %b rins %h rA %h expected 0 %h %h", out_valid, alu_R_ins, alu_rA, VOR, a2); end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n != 1 || out_rD !== 5'd7 || out_data !== (a2 | b2)) begin n_fail++; $display("FAIL vdiv_second_result: got lat %0d rd %0d data %h expected 1 7 %h", n, out_rD, out_data, a2 | b2); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vdiv_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_vmul_stall;
        int n;
        int n_bad;
        int n_extra;
        logic [63:0] a, b, exp_d;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        exp_d = alu_model(R_ALU, VMULEU, 2'b11, a, b);
        out_ready = 1'b0;
        @(posedge clk); #1;
        set_op(R_ALU, VMULEU, 2'b11, a, b, 5'd9);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n != LAT_MUL) begin n_fail++; $display("FAIL vmul_latency: got %0d expected %0d", n, LAT_MUL); end
        n_checks++; if (out_data !== exp_d || out_rD !== 5'd9 || out_wen !== 1'b1) begin n_fail++; $display("FAIL vmul_data: got %h/%0d/%b expected %h/9/1", out_data, out_rD, out_wen, exp_d); end
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_d || out_rD !== 5'd9 || in_ready !== 1'b0) n_bad++;
        end
        n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL vmul_hold: got %0d unstable cycles expected 0", n_bad); end
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL vmul_handshake: got valid %b busy %b expected 0 0", out_valid, busy); end
        n_extra = 0;
        repeat (3) begin @(posedge clk); @(negedge clk); if (out_valid !== 1'b0) n_extra++; end
        n_checks++; if (n_extra != 0) begin n_fail++; $display("FAIL vmul_single: got %0d extra valid cycles expected 0", n_extra); end
    endtask

    task automatic test_load;
        int n;
        logic [63:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(OP_LOAD, VDIV, 2'b01, a, b, 5'd3);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL load_latency: got %0d expected 1", n); end
        n_checks++; if (out_wen !== 1'b0 || out_data !== alu_model(OP_LOAD, VDIV, 2'b01, a, b)) begin n_fail++; $display("FAIL load_result: got wen %b data %h expected 0 %h", out_wen, out_data, alu_model(OP_LOAD, VDIV, 2'b01, a, b)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int n;
        int n_valid;
        logic [63:0] a, b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_op(R_ALU, VSQRT, 2'b10, {$urandom, $urandom}, {$urandom, $urandom}, 5'd12);
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got valid %b busy %b ready %b expected 0 0 1", out_valid, busy, in_ready); end
        n_checks++; if (alu_rA !== 64'd0 || alu_R_ins !== 6'd0) begin n_fail++; $display("FAIL midrst_alu_clear: got %h/%h expected 0/0", alu_rA, alu_R_ins); end
        n_valid = 0;
        repeat (12) begin @(posedge clk); @(negedge clk); if (out_valid !== 1'b0) n_valid++; end
        n_checks++; if (n_valid != 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d valid cycles expected 0", n_valid); end
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        @(posedge clk); #1;
        set_op(R_ALU, VAND, 2'b00, a, b, 5'd13);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (n != 1 || out_data !== (a & b) || out_rD !== 5'd13 || out_wen !== 1'b1) begin n_fail++; $display("FAIL midrst_vand: got lat %0d data %h rd %0d wen %b expected 1 %h 13 1", n, out_data, out_rD, out_wen, a & b); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] a [4];
        logic [63:0] b [4];
        logic [4:0]  rd [4];
        int i_in, n_out, cyc, last_cyc;
        logic acc;
        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom}; rd[i] = 5'(20 + i);
        end
        out_ready = 1'b1;
        i_in = 0; n_out = 0; cyc = 0; last_cyc = -1;
        @(posedge clk); #1;
        set_op(R_ALU, VOR, 2'b11, a[0], b[0], rd[0]);
        while (n_out < 4 && cyc < 40) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                n_checks++; if (out_rD !== rd[n_out] || out_data !== (a[n_out] | b[n_out])) begin n_fail++; $display("FAIL b2b_result%0d: got rd %0d data %h expected rd %0d data %h", n_out, out_rD, out_data, rd[n_out], a[n_out] | b[n_out]); end
                if (n_out > 0) begin
                    n_checks++; if (cyc - last_cyc != 2) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 2", n_out, cyc - last_cyc); end
                end
                last_cyc = cyc;
                n_out++;
            end
            @(posedge clk); #1; cyc++;
            if (acc) begin
                i_in++;
                if (i_in < 4) set_op(R_ALU, VOR, 2'b11, a[i_in], b[i_in], rd[i_in]);
                else in_valid = 1'b0;
            end
        end
        n_checks++; if (n_out != 4 || i_in != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results %0d accepts expected 4 4", n_out, i_in); end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wen_bounds;
        logic [5:0] codes [5];
        int n;
        codes = '{6'd0, 6'd1, 6'd18, 6'd19, 6'd63};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            set_op(R_ALU, codes[k], 2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 5'(k));
            @(posedge clk); #1; in_valid = 1'b0;
            @(negedge clk);
            n = 0;
            while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); n++; @(negedge clk); end
            n_checks++; if (n != exp_lat(R_ALU, codes[k]) || out_wen !== exp_wen(R_ALU, codes[k])) begin n_fail++; $display("FAIL wen_bound_%0d: got lat %0d wen %b expected %0d %b", codes[k], n, out_wen, exp_lat(R_ALU, codes[k]), exp_wen(R_ALU, codes[k])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        logic [5:0]  op, rins;
        logic [1:0]  ww;
        logic [63:0] a, b, exp_d;
        logic [4:0]  rd;
        int n, n_unstable, n_bad, stall;
        for (int t = 0; t < 40; t++) begin
            op   = ($urandom_range(0, 9) < 7) ? R_ALU : 6'($urandom_range(0, 63));
            rins = 6'($urandom_range(0, 23));
            ww   = 2'($urandom_range(0, 3));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            rd   = 5'($urandom_range(0, 31));
            exp_d = alu_model(op, rins, ww, a, b);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk); #1;
            set_op(op, rins, ww, a, b, rd);
            @(posedge clk); #1;
            set_op(6'($urandom), 6'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n = 0; n_unstable = 0;
            while (out_valid !== 1'b1 && n < 40) begin
                if (alu_rA !== a || alu_rB !== b || alu_Op_code !== op || alu_R_ins !== rins || alu_WW !== ww) n_unstable++;
                @(posedge clk); n++; #1;
                set_op(6'($urandom), 6'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
                in_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            n_checks++; if (n != exp_lat(op, rins)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, n, exp_lat(op, rins)); end
            n_checks++; if (n_unstable != 0) begin n_fail++; $display("FAIL rand%0d_alu_hold: got %0d changed cycles expected 0", t, n_unstable); end
            n_checks++; if (out_data !== exp_d || out_rD !== rd || out_wen !== exp_wen(op, rins)) begin n_fail++; $display("FAIL rand%0d_result: got %h/%0d/%b expected %h/%0d/%b", t, out_data, out_rD, out_wen, exp_d, rd, exp_wen(op, rins)); end
            @(posedge clk); #1; in_valid = 1'b0;
            stall = $urandom_range(0, 3);
            n_bad = 0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== exp_d || out_rD !== rd) n_bad++;
            end
            n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL rand%0d_hold: got %0d unstable cycles expected 0", t, n_bad); end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_drain: got valid %b busy %b expected 0 0", t, out_valid, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_vadd();
        test_vdiv_hold();
        test_vmul_stall();
        test_load();
        test_reset_mid_op();
        test_back_to_back();
        test_wen_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
